// File: rtl/vec_pkg.sv
// Shared types and constants for the operand-vector BRAM loader:
// command bytes, bank select and controller states.
package vec_pkg;

  localparam logic [7:0] CMD_SEL_A  = 8'h01;
  localparam logic [7:0] CMD_SEL_B  = 8'h02;
  localparam int         DATA_W_DEF = 10;

  typedef enum logic { BANK_A, BANK_B } bank_e;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    WRITE,
    FINISH
  } state_e;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_SEL_A) || (b == CMD_SEL_B);
  endfunction

endpackage

// File: rtl/bram_addr_counter.sv
// Saturating write-address counter: counts 0..DEPTH, holds at DEPTH and
// flags full so the controller can drop further words.
module bram_addr_counter #(
  parameter int DEPTH = 1024,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  assign full = (count == CNT_W'(DEPTH));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && !full) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bram_load_ctrl.sv
// Loads operand vectors from the UART word stream into BRAM bank A or B,
// selected by a command byte, and latches the stored length per bank.
module bram_load_ctrl
  import vec_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  input  logic              flag_data_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flag_end_write,
  output logic              flag_bram,
  output logic              bram_a_we,
  output logic              bram_b_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic [ADDR_W:0]   len_a,
  output logic [ADDR_W:0]   len_b,
  output logic              load_done,
  output logic              overflow,
  output logic              cmd_error,
  output logic              busy
);

  state_e              state, state_next;
  bank_e               bank;
  logic [DATA_W-1:0]   data_reg;
  logic                end_pending;
  logic [ADDR_W:0]     count;
  logic                full;
  logic                accept;
  logic                write_en;
  logic                cnt_en;

  // Commands are only honoured in IDLE; bytes seen while armed belong to the
  // concatenator.
  assign accept = (state == IDLE) && rx_ready && is_cmd(rx_data);

  bram_addr_counter #(
    .DEPTH (DEPTH),
    .CNT_W (ADDR_W + 1)
  ) u_addr_counter (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (cnt_en),
    .count (count),
    .full  (full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bank        <= BANK_A;
      data_reg    <= '0;
      end_pending <= 1'b0;
      overflow    <= 1'b0;
      cmd_error   <= 1'b0;
      len_a       <= '0;
      len_b       <= '0;
    end else begin
      state     <= state_next;
      cmd_error <= (state == IDLE) && rx_ready && !is_cmd(rx_data);

      case (state)
        IDLE: begin
          if (accept) begin
            bank        <= (rx_data == CMD_SEL_B) ? BANK_B : BANK_A;
            overflow    <= 1'b0;
            end_pending <= 1'b0;
          end
        end
        ARM: begin
          if (flag_data_ready) begin
            data_reg    <= data_in;
            end_pending <= flag_end_write;
          end
        end
        WRITE: begin
          if (full)           overflow    <= 1'b1;
          if (flag_end_write) end_pending <= 1'b1;
        end
        FINISH: begin
          if (bank == BANK_A) len_a <= count;
          else                len_b <= count;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    flag_bram  = 1'b0;
    write_en   = 1'b0;
    cnt_en     = 1'b0;
    load_done  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) state_next = ARM;
      end
      ARM: begin
        flag_bram = 1'b1;
        if (flag_data_ready)     state_next = WRITE;
        else if (flag_end_write) state_next = FINISH;
      end
      WRITE: begin
        flag_bram  = 1'b1;
        write_en   = !full;
        cnt_en     = !full;
        state_next = (end_pending || flag_end_write) ? FINISH : ARM;
      end
      FINISH: begin
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bram_a_we  = write_en && (bank == BANK_A);
  assign bram_b_we  = write_en && (bank == BANK_B);
  assign bram_addr  = count[ADDR_W-1:0];
  assign bram_wdata = data_reg;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_bram_load_ctrl.sv
// Directed bench for bram_load_ctrl with DEPTH=4 so the overflow boundary is
// reachable with a handful of words.
module tb_bram_load_ctrl;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rx_ready = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              flag_data_ready = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              flag_end_write = 1'b0;
  logic              flag_bram, bram_a_we, bram_b_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic [ADDR_W:0]   len_a, len_b;
  logic              load_done, overflow, cmd_error, busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Write monitor: logs every bank write seen away from the clock edge.
  int wa_addr[$], wa_data[$], wb_addr[$], wb_data[$];
  int done_cnt = 0;
  int both_cnt = 0;

  bram_load_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_ready        (rx_ready),
    .rx_data         (rx_data),
    .flag_data_ready (flag_data_ready),
    .data_in         (data_in),
    .flag_end_write  (flag_end_write),
    .flag_bram       (flag_bram),
    .bram_a_we       (bram_a_we),
    .bram_b_we       (bram_b_we),
    .bram_addr       (bram_addr),
    .bram_wdata      (bram_wdata),
    .len_a           (len_a),
    .len_b           (len_b),
    .load_done       (load_done),
    .overflow        (overflow),
    .cmd_error       (cmd_error),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bram_a_we) begin
      wa_addr.push_back(int'(bram_addr));
      wa_data.push_back(int'(bram_wdata));
    end
    if (bram_b_we) begin
      wb_addr.push_back(int'(bram_addr));
      wb_data.push_back(int'(bram_wdata));
    end
    if (bram_a_we && bram_b_we) both_cnt++;
    if (load_done) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    tick(1);
    rx_ready = 1'b1;
    rx_data  = b;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    tick(1);
    flag_data_ready = 1'b1;
    data_in         = w;
    tick(1);
    flag_data_ready = 1'b0;
    tick(3);
  endtask

  task automatic send_end();
    tick(1);
    flag_end_write = 1'b1;
    tick(1);
    flag_end_write = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    @(negedge clk);
    n_cmp++;
    if ({flag_bram, bram_a_we, bram_b_we, bram_addr, bram_wdata, len_a, len_b,
         load_done, overflow, cmd_error, busy} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got flag_bram=%b a_we=%b b_we=%b addr=%0d wdata=%h len_a=%0d len_b=%0d done=%b ovf=%b cerr=%b busy=%b, want all 0",
               flag_bram, bram_a_we, bram_b_we, bram_addr, bram_wdata, len_a, len_b,
               load_done, overflow, cmd_error, busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_load_a();
    int a0, b0, d0;
    int exp_d[3] = '{'h155, 'h2AA, 'h001};
    a0 = wa_addr.size(); b0 = wb_addr.size(); d0 = done_cnt;
    send_cmd(8'h01);
    @(negedge clk);
    n_cmp++;
    if (flag_bram !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL load_a_armed: flag_bram=%b busy=%b, want 1 1", flag_bram, busy);
    end
    // Latency: word pulse at cycle t, write enable at t+1.
    tick(1);
    flag_data_ready = 1'b1;
    data_in         = 10'h155;
    tick(1);
    flag_data_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bram_a_we !== 1'b1 || bram_addr !== 2'd0 || bram_wdata !== 10'h155) begin
      n_bad++;
      $display("FAIL load_a_latency: we=%b addr=%0d data=%h, want 1 0 155", bram_a_we, bram_addr, bram_wdata);
    end
    tick(3);
    send_word(10'h2AA);
    send_word(10'h001);
    send_end();
    n_cmp++;
    if (wa_addr.size() - a0 != 3 || wb_addr.size() != b0) begin
      n_bad++;
      $display("FAIL load_a_count: a writes=%0d b writes=%0d, want 3 0", wa_addr.size() - a0, wb_addr.size() - b0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (wa_addr[a0+i] != i || wa_data[a0+i] != exp_d[i]) begin
          n_bad++;
          $display("FAIL load_a_write%0d: addr=%0d data=%h, want %0d %h", i, wa_addr[a0+i], wa_data[a0+i], i, exp_d[i]);
        end
      end
    end
    n_cmp++;
    if (len_a !== 3'd3 || done_cnt - d0 != 1 || flag_bram !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL load_a_close: len_a=%0d done=%0d flag_bram=%b busy=%b, want 3 1 0 0", len_a, done_cnt - d0, flag_bram, busy);
    end
  endtask

  task automatic test_empty_b();
    int a0, b0, d0;
    a0 = wa_addr.size(); b0 = wb_addr.size(); d0 = done_cnt;
    send_cmd(8'h02);
    send_end();
    n_cmp++;
    if (wa_addr.size() != a0 || wb_addr.size() != b0 || done_cnt - d0 != 1) begin
      n_bad++;
      $display("FAIL empty_b_writes: a=%0d b=%0d done=%0d, want 0 0 1", wa_addr.size() - a0, wb_addr.size() - b0, done_cnt - d0);
    end
    n_cmp++;
    if (len_b !== 3'd0 || len_a !== 3'd3) begin
      n_bad++;
      $display("FAIL empty_b_len: len_b=%0d len_a=%0d, want 0 3", len_b, len_a);
    end
  endtask

  task automatic test_overflow();
    int a0;
    a0 = wa_addr.size();
    send_cmd(8'h01);
    for (int i = 0; i < 6; i++) send_word(DATA_W'(10'h100 + i));
    send_end();
    n_cmp++;
    if (wa_addr.size() - a0 != 4) begin
      n_bad++;
      $display("FAIL ovf_count: writes=%0d, want 4", wa_addr.size() - a0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (wa_addr[a0+i] != i || wa_data[a0+i] != 'h100 + i) begin
          n_bad++;
          $display("FAIL ovf_write%0d: addr=%0d data=%h, want %0d %h", i, wa_addr[a0+i], wa_data[a0+i], i, 'h100 + i);
        end
      end
    end
    n_cmp++;
    if (overflow !== 1'b1 || len_a !== 3'd4) begin
      n_bad++;
      $display("FAIL ovf_flags: overflow=%b len_a=%0d, want 1 4", overflow, len_a);
    end
    send_cmd(8'h01);
    @(negedge clk);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_clear: overflow=%b, want 0", overflow);
    end
    send_end();
  endtask

  task automatic test_bad_cmd();
    int ce = 0;
    int armed = 0;
    send_cmd(8'h7E);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cmd_error) ce++;
      if (flag_bram || busy) armed++;
    end
    n_cmp++;
    if (ce != 1 || armed != 0) begin
      n_bad++;
      $display("FAIL bad_cmd: cmd_error cycles=%0d armed cycles=%0d, want 1 0", ce, armed);
    end
  endtask

  task automatic test_reset_mid_load();
    int b0;
    b0 = wb_addr.size();
    send_cmd(8'h02);
    send_word(10'h011);
    send_word(10'h022);
    n_cmp++;
    if (wb_addr.size() - b0 != 2) begin
      n_bad++;
      $display("FAIL rst_pre_writes: b writes=%0d, want 2", wb_addr.size() - b0);
    end
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({flag_bram, bram_a_we, bram_b_we, bram_addr, bram_wdata, len_a, len_b,
         load_done, overflow, cmd_error, busy} !== 25'd0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: flag_bram=%b addr=%0d wdata=%h len_a=%0d len_b=%0d busy=%b, want all 0",
               flag_bram, bram_addr, bram_wdata, len_a, len_b, busy);
    end
    b0 = wb_addr.size();
    send_cmd(8'h02);
    send_word(10'h0AB);
    send_end();
    n_cmp++;
    if (wb_addr.size() - b0 != 1 || wb_addr[b0] != 0 || wb_data[b0] != 'h0AB || len_b !== 3'd1) begin
      n_bad++;
      $display("FAIL rst_reload: b writes=%0d len_b=%0d, want 1 write at addr 0 data 0ab and len_b 1", wb_addr.size() - b0, len_b);
    end
  endtask

  task automatic test_simultaneous();
    send_cmd(8'h01);
    send_word(10'h123);
    tick(1);
    flag_data_ready = 1'b1;
    flag_end_write  = 1'b1;
    data_in         = 10'h3C5;
    tick(1);
    flag_data_ready = 1'b0;
    flag_end_write  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bram_a_we !== 1'b1 || bram_addr !== 2'd1 || bram_wdata !== 10'h3C5 || load_done !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_write: we=%b addr=%0d data=%h done=%b, want 1 1 3c5 0", bram_a_we, bram_addr, bram_wdata, load_done);
    end
    @(negedge clk);
    n_cmp++;
    if (load_done !== 1'b1 || bram_a_we !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_done: done=%b we=%b, want 1 0", load_done, bram_a_we);
    end
    tick(2);
    n_cmp++;
    if (len_a !== 3'd2 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_len: len_a=%0d busy=%b, want 2 0", len_a, busy);
    end
  endtask

  initial begin
    test_reset();
    test_load_a();
    test_empty_b();
    test_overflow();
    test_bad_cmd();
    test_reset_mid_load();
    test_simultaneous();
    n_cmp++;
    if (both_cnt != 0) begin
      n_bad++;
      $display("FAIL bank_exclusive: both we high in %0d cycles, want 0", both_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
